// File: rtl/blit_write_combiner.sv
// blit_write_combiner
// Last stage of the blitter pixel pipeline. Packs byte writes into masked
// 32-bit word writes and queues them in a small FIFO. The FIFO drains to
// the memory arbiter through a mem_req/mem_ready handshake.
//
// Build option: define BLIT_WRITE_COMBINE_EN to include the combine register.
// If it is not defined, every accepted byte becomes its own single-lane word
// write. That write carries the byte replicated across all four lanes.
module blit_write_combiner #(
  parameter int ADDR_WIDTH = 26,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  stall,
  input  logic [7:0]            p5_data,
  input  logic                  p5_write,
  input  logic [ADDR_WIDTH-1:0] p5_addr,
  input  logic                  flush,
  output logic                  stall_req,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-3:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wmask,
  input  logic                  mem_ready,
  output logic                  idle
);

  localparam int WA_W  = ADDR_WIDTH - 2;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0] C_DEPTH = (PTR_W + 1)'(FIFO_DEPTH);

  // Single-bit byte enable for a little-endian lane number.
  function automatic logic [3:0] lane_mask(input logic [1:0] lane);
    return 4'b0001 << lane;
  endfunction

  // Widen a 4-bit byte mask into a 32-bit bit mask.
  function automatic logic [31:0] mask_expand(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  // Replace the enabled lanes of old_d with the matching lanes of new_d.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_d,
                                             input logic [31:0] new_d,
                                             input logic [3:0]  m);
    return (old_d & ~mask_expand(m)) | (new_d & mask_expand(m));
  endfunction

  // Decode the incoming byte into its word address, lane and data.
  logic [1:0]      w_lane;
  logic [WA_W-1:0] w_word;
  logic [3:0]      w_bmask;
  logic [31:0]     w_bdata_rep;

  assign w_lane      = p5_addr[1:0];
  assign w_word      = p5_addr[ADDR_WIDTH-1:2];
  assign w_bmask     = lane_mask(w_lane);
  assign w_bdata_rep = {4{p5_data}};

  // FIFO push/pop interface, driven by whichever front end is built.
  logic            w_push;
  logic            w_pop;
  logic [WA_W-1:0] w_push_addr;
  logic [31:0]     w_push_data;
  logic [3:0]      w_push_mask;
  logic            w_full;
  logic            w_empty;
  logic            w_accept;

`ifdef BLIT_WRITE_COMBINE_EN
  // Combine register: one word being assembled from consecutive bytes.
  logic            r_cv;
  logic [WA_W-1:0] r_caddr;
  logic [31:0]     r_cdata;
  logic [3:0]      r_cmask;

  logic            w_cv_nx;
  logic [WA_W-1:0] w_caddr_nx;
  logic [31:0]     w_cdata_nx;
  logic [3:0]      w_cmask_nx;
  logic            w_same;
  logic            w_push_flush;

  assign w_same = (r_caddr == w_word);

  // A new word needs a FIFO slot for the word being evicted. Only the
  // incoming byte and registered state decide this, so there is no loop
  // through stall or mem_ready.
  assign stall_req = p5_write & r_cv & ~w_same & w_full;

  // stall already includes stall_req. The extra term keeps a misbehaving
  // stall network from pushing into a full FIFO.
  assign w_accept = p5_write & ~stall & ~stall_req;

  // Flush has lower priority than a byte in the same cycle. It retries later.
  assign w_push_flush = flush & r_cv & ~w_accept & ~w_full;

  assign w_push      = (w_accept & r_cv & ~w_same) | w_push_flush;
  assign w_push_addr = r_caddr;
  assign w_push_data = r_cdata;
  assign w_push_mask = r_cmask;

  assign idle = ~r_cv & w_empty;

  // Next-state of the combine register: merge, reload, or clear on flush.
  always_comb begin
    w_cv_nx    = r_cv;
    w_caddr_nx = r_caddr;
    w_cdata_nx = r_cdata;
    w_cmask_nx = r_cmask;
    if (w_accept) begin
      if (r_cv && w_same) begin
        // Same word: last byte written to a lane wins.
        w_cdata_nx = lane_merge(r_cdata, w_bdata_rep, w_bmask);
        w_cmask_nx = r_cmask | w_bmask;
      end else begin
        // Empty register, or the old word was just pushed: start a new word.
        w_cv_nx    = 1'b1;
        w_caddr_nx = w_word;
        w_cdata_nx = w_bdata_rep & mask_expand(w_bmask);
        w_cmask_nx = w_bmask;
      end
    end else if (w_push_flush) begin
      w_cv_nx = 1'b0;
    end else begin
      w_cv_nx = r_cv;
    end
  end

  // Combine register state, cleared by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cv    <= 1'b0;
      r_caddr <= {WA_W{1'b0}};
      r_cdata <= 32'h0000_0000;
      r_cmask <= 4'h0;
    end else begin
      r_cv    <= w_cv_nx;
      r_caddr <= w_caddr_nx;
      r_cdata <= w_cdata_nx;
      r_cmask <= w_cmask_nx;
    end
  end
`else
  // No combining: flush only waits for the FIFO to drain, which idle reports.
  logic w_unused;

  assign w_unused = flush;

  // Every byte needs its own FIFO slot.
  assign stall_req = p5_write & w_full;
  assign w_accept  = p5_write & ~stall & ~stall_req;

  assign w_push      = w_accept;
  assign w_push_addr = w_word;
  assign w_push_data = w_bdata_rep;
  assign w_push_mask = w_bmask;

  assign idle = w_empty;
`endif

  // Word FIFO. The depth is a power of two, so the pointers wrap naturally.
  logic [WA_W-1:0]  r_fifo_addr [FIFO_DEPTH];
  logic [31:0]      r_fifo_data [FIFO_DEPTH];
  logic [3:0]       r_fifo_mask [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == {(PTR_W + 1){1'b0}});
  assign w_pop   = ~w_empty & mem_ready;

  // FIFO storage write. Stale entries are never visible, because the head
  // outputs are gated by empty.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= w_push_addr;
      r_fifo_data[r_wr_ptr] <= w_push_data;
      r_fifo_mask[r_wr_ptr] <= w_push_mask;
    end
  end

  // FIFO pointers and occupancy. Reset discards all queued words.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {(PTR_W + 1){1'b0}};
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Head of the FIFO. It stays stable until it is popped, and reads zero when empty.
  assign mem_req   = ~w_empty;
  assign mem_addr  = w_empty ? {WA_W{1'b0}} : r_fifo_addr[r_rd_ptr];
  assign mem_wdata = w_empty ? 32'h0000_0000 : r_fifo_data[r_rd_ptr];
  assign mem_wmask = w_empty ? 4'h0 : r_fifo_mask[r_rd_ptr];

endmodule

// File: tb/tb_blit_write_combiner.sv
// Directed testbench for blit_write_combiner. Expectations follow the
// BLIT_WRITE_COMBINE_EN setting of the build.
module tb_blit_write_combiner;

  localparam int AW = 26;

  typedef struct packed {
    logic [AW-3:0] a;
    logic [31:0]   d;
    logic [3:0]    m;
  } req_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          r_ext_stall;
  logic          stall;
  logic [7:0]    p5_data;
  logic          p5_write;
  logic [AW-1:0] p5_addr;
  logic          flush;
  logic          stall_req;
  logic          mem_req;
  logic [AW-3:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wmask;
  logic          mem_ready;
  logic          idle;

  int checks = 0;
  int errors = 0;
  req_t q[$];

  blit_write_combiner #(.ADDR_WIDTH(AW), .FIFO_DEPTH(4)) dut (
    .clock(clock), .reset(reset), .stall(stall), .p5_data(p5_data),
    .p5_write(p5_write), .p5_addr(p5_addr), .flush(flush),
    .stall_req(stall_req), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ready(mem_ready),
    .idle(idle)
  );

  always #5 clock = ~clock;

  // Global stall is the OR of every stall source, including this block's own request.
  assign stall = r_ext_stall | stall_req;

  // Arbiter side: record every accepted memory write.
  always @(posedge clock) begin
    if (!reset && mem_req && mem_ready) q.push_back({mem_addr, mem_wdata, mem_wmask});
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [AW-1:0] a, input logic [7:0] d);
    p5_write = 1'b1;
    p5_addr  = a;
    p5_data  = d;
    #1;
  endtask

  // Present a byte and keep it there until an edge accepts it.
  task automatic send_byte(input logic [AW-1:0] a, input logic [7:0] d);
    bit ok;
    ok = 1'b0;
    drive(a, d);
    for (int k = 0; k < 100 && !ok; k++) begin
      ok = !stall;
      tick();
    end
    p5_write = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_byte timeout: addr=%h not accepted, required acceptance within 100 cycles", a);
    end
  endtask

  // Hold flush until the block reports idle.
  task automatic flush_wait(input string name);
    bit ok;
    ok = 1'b0;
    flush = 1'b1;
    #1;
    for (int k = 0; k < 100 && !ok; k++) begin
      if (idle) ok = 1'b1;
      else tick();
    end
    flush = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s flush: idle=%b, required 1 within 100 cycles", name, idle);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset mem_req: got %b want 0", mem_req); end
    checks++; if (mem_addr !== 24'h0) begin errors++; $display("FAIL reset mem_addr: got %h want 0", mem_addr); end
    checks++; if (mem_wdata !== 32'h0) begin errors++; $display("FAIL reset mem_wdata: got %h want 0", mem_wdata); end
    checks++; if (mem_wmask !== 4'h0) begin errors++; $display("FAIL reset mem_wmask: got %h want 0", mem_wmask); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset idle: got %b want 1", idle); end
    drive(26'h100, 8'h00);
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset stall_req: got %b want 0", stall_req); end
    p5_write = 1'b0;
  endtask

  task automatic test_full_word();
    req_t exp[$];
    logic [7:0] b;
    logic [3:0] m;
`ifdef BLIT_WRITE_COMBINE_EN
    exp.push_back({24'h000040, 32'h44332211, 4'hF});
`else
    for (int i = 0; i < 4; i++) begin
      b = 8'(8'h11 * (i + 1));
      m = 4'b0001 << i;
      exp.push_back({24'h000040, {4{b}}, m});
    end
`endif
    q.delete();
    mem_ready = 1'b1;
    send_byte(26'h100, 8'h11);
    send_byte(26'h101, 8'h22);
    send_byte(26'h102, 8'h33);
    send_byte(26'h103, 8'h44);
    flush_wait("full_word");
    tick();
    checks++; if (q.size() !== exp.size()) begin errors++; $display("FAIL full_word count: got %0d want %0d", q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < q.size(); i++) begin
      checks++;
      if (q[i] !== exp[i]) begin errors++; $display("FAIL full_word[%0d]: got %h/%h/%h want %h/%h/%h", i, q[i].a, q[i].d, q[i].m, exp[i].a, exp[i].d, exp[i].m); end
    end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL full_word idle: got %b want 1", idle); end
  endtask

  task automatic test_partial();
    req_t exp[$];
`ifdef BLIT_WRITE_COMBINE_EN
    exp.push_back({24'h000081, 32'h0000AA00, 4'h2});
    exp.push_back({24'h000083, 32'h000000BB, 4'h1});
`else
    exp.push_back({24'h000081, 32'hAAAAAAAA, 4'h2});
    exp.push_back({24'h000083, 32'hBBBBBBBB, 4'h1});
`endif
    q.delete();
    mem_ready = 1'b1;
    send_byte(26'h205, 8'hAA);
    send_byte(26'h20C, 8'hBB);
    flush_wait("partial");
    tick();
    checks++; if (q.size() !== exp.size()) begin errors++; $display("FAIL partial count: got %0d want %0d", q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < q.size(); i++) begin
      checks++;
      if (q[i] !== exp[i]) begin errors++; $display("FAIL partial[%0d]: got %h/%h/%h want %h/%h/%h", i, q[i].a, q[i].d, q[i].m, exp[i].a, exp[i].d, exp[i].m); end
    end
  endtask

  task automatic test_overwrite_stall();
    req_t exp[$];
`ifdef BLIT_WRITE_COMBINE_EN
    exp.push_back({24'h000004, 32'h00000002, 4'h1});
`else
    exp.push_back({24'h000004, 32'h01010101, 4'h1});
    exp.push_back({24'h000004, 32'h02020202, 4'h1});
`endif
    q.delete();
    mem_ready = 1'b1;
    send_byte(26'h010, 8'h01);
    r_ext_stall = 1'b1;
    drive(26'h010, 8'h02);
    for (int k = 0; k < 3; k++) tick();
    r_ext_stall = 1'b0;
    send_byte(26'h010, 8'h02);
    flush_wait("overwrite");
    tick();
    checks++; if (q.size() !== exp.size()) begin errors++; $display("FAIL overwrite count: got %0d want %0d", q.size(), exp.size()); end
    for (int i = 0; i < exp.size() && i < q.size(); i++) begin
      checks++;
      if (q[i] !== exp[i]) begin errors++; $display("FAIL overwrite[%0d]: got %h/%h/%h want %h/%h/%h", i, q[i].a, q[i].d, q[i].m, exp[i].a, exp[i].d, exp[i].m); end
    end
  endtask

  task automatic test_backpressure();
    int stall_idx;
    logic [AW-1:0] a;
    logic [7:0] d;
    req_t e;
`ifdef BLIT_WRITE_COMBINE_EN
    stall_idx = 5;
`else
    stall_idx = 4;
`endif
    q.delete();
    mem_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a = 26'h400 + AW'(4 * i);
      d = 8'h50 + 8'(i);
      drive(a, d);
      checks++;
      if (stall_req !== (i == stall_idx)) begin errors++; $display("FAIL backpressure stall_req byte %0d: got %b want %b", i, stall_req, (i == stall_idx)); end
      if (i == stall_idx) begin
        for (int k = 0; k < 3; k++) begin
          tick();
          checks++;
          if (stall_req !== 1'b1 || mem_req !== 1'b1) begin errors++; $display("FAIL backpressure hold %0d: stall_req=%b mem_req=%b want 1/1", k, stall_req, mem_req); end
        end
        mem_ready = 1'b1;
        #1;
        checks++;
        if (stall_req !== 1'b1) begin errors++; $display("FAIL backpressure pop-cycle stall_req: got %b want 1", stall_req); end
        send_byte(a, d);
      end else begin
        send_byte(a, d);
      end
    end
    flush_wait("backpressure");
    tick();
    checks++; if (q.size() !== 6) begin errors++; $display("FAIL backpressure count: got %0d want 6", q.size()); end
    for (int i = 0; i < 6 && i < q.size(); i++) begin
      d = 8'h50 + 8'(i);
`ifdef BLIT_WRITE_COMBINE_EN
      e = {24'h000100 + 24'(i), {24'h000000, d}, 4'h1};
`else
      e = {24'h000100 + 24'(i), {4{d}}, 4'h1};
`endif
      checks++;
      if (q[i] !== e) begin errors++; $display("FAIL backpressure[%0d]: got %h/%h/%h want %h/%h/%h", i, q[i].a, q[i].d, q[i].m, e.a, e.d, e.m); end
    end
  endtask

  task automatic test_latency();
    q.delete();
    mem_ready = 1'b0;
    send_byte(26'h040, 8'h5A);
`ifdef BLIT_WRITE_COMBINE_EN
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL latency first mem_req: got %b want 0", mem_req); end
`else
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL latency first mem_req: got %b want 1", mem_req); end
`endif
    send_byte(26'h044, 8'hA5);
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL latency second mem_req: got %b want 1", mem_req); end
    checks++; if (mem_addr !== 24'h000010) begin errors++; $display("FAIL latency head addr: got %h want 000010", mem_addr); end
    mem_ready = 1'b1;
    flush_wait("latency");
    tick();
    checks++; if (q.size() !== 2) begin errors++; $display("FAIL latency count: got %0d want 2", q.size()); end
    if (q.size() == 2) begin
      checks++; if (q[1].a !== 24'h000011) begin errors++; $display("FAIL latency second addr: got %h want 000011", q[1].a); end
    end
  endtask

  task automatic test_reset_mid();
    q.delete();
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_byte(26'h800 + AW'(4 * i), 8'hC0 + 8'(i));
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL reset_mid pre mem_req: got %b want 1", mem_req); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mid mem_req: got %b want 0", mem_req); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_mid idle: got %b want 1", idle); end
    mem_ready = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    checks++; if (q.size() !== 0) begin errors++; $display("FAIL reset_mid stale requests: got %0d want 0", q.size()); end
  endtask

  initial begin
    reset       = 1'b1;
    r_ext_stall = 1'b0;
    p5_write    = 1'b0;
    p5_addr     = 26'h0;
    p5_data     = 8'h00;
    flush       = 1'b0;
    mem_ready   = 1'b0;
    test_reset();
    test_full_word();
    test_partial();
    test_overwrite_stall();
    test_backpressure();
    test_latency();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/blit_write_combiner.md
# blit_write_combiner

Final stage of the blitter pixel pipeline. Consumes the byte-wide `p5_data`/`p5_write` stream plus its byte address, merges consecutive bytes that fall in the same 32-bit word into one masked write, and queues the words in a small FIFO. The FIFO drains to the memory arbiter through a valid/ready handshake. The block raises a stall request when it cannot accept a byte, and reports idle so the blit controller can tell when a blit has fully landed in memory.

## Interface
- `ADDR_WIDTH`, 26: byte address width.
- `FIFO_DEPTH`, 4: word FIFO entries; must be a power of two, at least 2.
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: global pipeline stall (OR of all stall requests, including `stall_req`). No input is consumed while high.
- `p5_data` in 8: pixel byte.
- `p5_write` in 1: `p5_data` is a valid byte to write.
- `p5_addr` in ADDR_WIDTH: byte address of `p5_data`.
- `flush` in 1: level, held by the controller at end of blit until `idle`=1.
- `stall_req` out 1: combinational; this block cannot accept the current byte.
- `mem_req` out 1: FIFO head valid.
- `mem_addr` out ADDR_WIDTH-2: word address of head.
- `mem_wdata` out 32: head data.
- `mem_wmask` out 4: head byte enables.
- `mem_ready` in 1: arbiter accepts head this cycle.
- `idle` out 1: combine register empty, FIFO empty.

## Operation
- Byte lane rule: lane n = `p5_addr[1:0]`. The byte goes to `wdata[8n+7:8n]` and sets `mask[n]` (little-endian).
- Combine register: `cv` (valid), `caddr` (word address), `cdata`, `cmask`.
- A byte is accepted when `p5_write`=1 and `stall`=0.
- Accepted byte with `cv`=1 and the same word address: merge the byte into `cdata`/`cmask`. Rewriting the same lane overwrites it; the last byte wins.
- Accepted byte with `cv`=1 and a different word: push {`caddr`,`cdata`,`cmask`} into the FIFO, then load the new byte with a single-bit mask.
- Accepted byte with `cv`=0: load the combine register.
- `stall_req` = `p5_write` & `cv` & (word address differs) & FIFO full. There is no same-cycle pass-through; a pop in the same cycle does not clear `stall_req`.
- Flush: if `flush`=1, `cv`=1, no byte accepted this cycle, and FIFO not full, push the combine register and clear `cv`. A byte accepted in the same cycle takes priority; flush retries on a later cycle.
- FIFO:
  - Push at the clock edge.
  - `mem_req` = not empty.
  - Pop when `mem_req`&`mem_ready`.
  - Simultaneous push and pop is legal at any occupancy below full.
  - Entries leave in push order.
  - Head outputs hold stable while `mem_req`=1 and `mem_ready`=0.
- `idle` = !`cv` & FIFO empty.
- Reset mid-operation discards the combine register and all FIFO entries; no further memory requests are issued for discarded data.

## Timing
- Reset values:
  - `cv`=0, FIFO empty.
  - `mem_req`=0, `mem_addr`/`mem_wdata`/`mem_wmask`=0.
  - `idle`=1.
  - `stall_req`=0 (follows from `cv`=0).
- Combining build, latency:
  - A word is pushed on the edge that accepts the first byte of the next word, or on the flush edge.
  - `mem_req` rises on the cycle after the push.
- Non-combining build: a byte accepted at edge N gives `mem_req`=1 in cycle N+1 (if it is at the FIFO head).
- Throughput: one byte accepted per cycle; one word popped per cycle.
- `stall_req` depends on `p5_*` and registered state only, never on `stall` or `mem_ready`, so there is no combinational loop.

## Configuration
- `BLIT_WRITE_COMBINE_EN` defined: combine register present, behaviour as above.
- Not defined:
  - Combine register removed; every accepted byte is pushed directly as {`p5_addr[ADDR_WIDTH-1:2]`, byte replicated to all four lanes, single-bit mask}.
  - `stall_req` = `p5_write` & FIFO full.
  - `flush` has no effect beyond waiting for the FIFO to drain.
  - `idle` = FIFO empty.

## Test plan
- Combine a full word: bytes 0x11,0x22,0x33,0x44 at 0x100–0x103, then `flush`, `mem_ready`=1 → exactly one request: `mem_addr`=0x40, `mem_wdata`=0x44332211, `mem_wmask`=0xF; then `idle`=1.
- Partial words: bytes 0xAA@0x205, then 0xBB@0x20C, then flush → two requests: {0x81, 0x0000AA00, 0x2} then {0x83, 0x000000BB, 0x1}.
- Backpressure: `mem_ready`=0, bytes to 6 distinct words with FIFO_DEPTH=4 →
  - `stall_req` asserts on the 6th byte; that byte is held, not lost.
  - Releasing `mem_ready` drains 5 words in order with no duplicates.
- Overwrite and stall-hold: byte 0x01@0x10, then 0x02@0x10; plus `stall`=1 held 3 cycles with `p5_write`=1 → single request with `wdata[7:0]`=0x02, mask 0x1; no repeated merges during the stall.
- Reset mid-blit: 3 words queued and `mem_ready`=0, pulse `reset` → `mem_req`=0, `idle`=1 next cycle; no stale requests afterwards.
- Without `BLIT_WRITE_COMBINE_EN`: 4 bytes at 0x100–0x103 → 4 requests, each to `mem_addr` 0x40, with masks 0x1, 0x2, 0x4, 0x8.
